norm_shift_seq: RTL and testbench

- Parametrised, multi-cycle left-shift normaliser for the FP datapath. It is the sequential successor to the fixed shift-by-2 left shifter.
- It takes a mantissa and a biased exponent, then shifts left by up to STEP bits per cycle until the MSB is 1 or the exponent reaches its minimum normal value of 1. The exponent decrements by the amount shifted.
- Sits between the mantissa adder/multiplier and the rounding stage, with valid/ready handshakes on both sides.

---
 rtl/fp_norm_pkg.sv | 19 +
 rtl/norm_shift_seq_if.sv | 37 +++
 rtl/lzc_window.sv | 22 ++
 rtl/norm_shift_seq.sv | 122 ++++++++++++
 tb/tb_norm_shift_seq.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - shared types, defaults and helpers for the FP left-shift normaliser
package fp_norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_STEP  = 2;
  localparam int DEF_EXP_W = 11;

  // Unsigned minimum, used to clamp the shift so the exponent never drops below 1.
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/norm_shift_seq_if.sv
// rtl/norm_shift_seq_if.sv - operand/result handshake bundle for norm_shift_seq
// Ports (as interface signals):
//   in_valid/in_ready      operand handshake, in_mant/in_exp operand payload
//   out_valid/out_ready    result handshake
//   out_mant/out_exp/out_shamt/out_zero/out_denorm  result payload
// Modports: slave = normaliser view, master = producer/consumer view.
interface norm_shift_seq_if
  import fp_norm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXP_W = DEF_EXP_W,
  parameter int SHW   = $clog2(WIDTH + 1)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mant;
  logic [EXP_W-1:0] in_exp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic [SHW-1:0]   out_shamt;
  logic             out_zero;
  logic             out_denorm;

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_shamt, out_zero, out_denorm
  );

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_shamt, out_zero, out_denorm
  );

endinterface

// File: rtl/lzc_window.sv
// rtl/lzc_window.sv - combinational leading-zero counter over an N-bit window
// Ports:
//   din    N-bit input, MSB first
//   count  number of leading zeros, N when din is all zero
module lzc_window #(
  parameter int N = 2
) (
  input  logic [N-1:0]             din,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int CW = $clog2(N + 1);

  // Scanning upward lets the highest set bit write last and win.
  always_comb begin
    count = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (din[i]) count = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/norm_shift_seq.sv
// rtl/norm_shift_seq.sv - multi-cycle left-shift normaliser (mantissa + biased exponent)
// Ports:
//   clk   clock, all state on rising edge
//   rst   asynchronous active-high reset
//   bus   norm_shift_seq_if.slave: operand in (valid/ready/mant/exp),
//         result out (valid/ready/mant/exp/shamt/zero/denorm)
// Build option: NORM_SINGLE_CYCLE_EN selects a full-width count and barrel
// shift finishing in one SHIFT cycle; otherwise up to STEP bits per cycle.
module norm_shift_seq
  import fp_norm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP,
  parameter int EXP_W = DEF_EXP_W
) (
  input  logic             clk,
  input  logic             rst,
  norm_shift_seq_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH + 1);
`ifdef NORM_SINGLE_CYCLE_EN
  localparam int LZN = WIDTH;
`else
  localparam int LZN = STEP;
`endif
  localparam int LZW = $clog2(LZN + 1);

  state_t           state_q, state_d;
  logic             load, advance, shift_done;

  logic [WIDTH-1:0] mant_q, mant_nx;
  logic [EXP_W-1:0] exp_q, exp_nx;
  logic [SHW-1:0]   shamt_q, shamt_nx, k;
  logic             zero_q, denorm_q;
  logic             mant_zero;
  logic [LZN-1:0]   win;
  logic [LZW-1:0]   lz;

  assign mant_zero = (mant_q == '0);
  assign win       = mant_q[WIDTH-1 -: LZN];

  lzc_window #(.N(LZN)) u_lzc (
    .din   (win),
    .count (lz)
  );

  // k is forced to 0 for a zero mantissa so a zero operand never picks up
  // a shift count or exponent decrement, and for exp==0 (already denormal).
  always_comb begin
    k = '0;
    if (!mant_zero && exp_q != '0)
      k = SHW'(min_u(32'(lz), 32'(exp_q) - 32'd1));
    mant_nx  = mant_q << k;
    exp_nx   = exp_q - EXP_W'(k);
    shamt_nx = shamt_q + k;
  end

`ifdef NORM_SINGLE_CYCLE_EN
  assign shift_done = 1'b1;
`else
  assign shift_done = mant_zero || (k == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        advance = 1'b1;
        if (shift_done) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags are refreshed every SHIFT cycle; on the exit cycle k==0 (or the
  // single-cycle shift has just been applied) so they describe the final word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mant_q   <= '0;
      exp_q    <= '0;
      shamt_q  <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
    end else if (load) begin
      mant_q  <= bus.in_mant;
      exp_q   <= bus.in_exp;
      shamt_q <= '0;
    end else if (advance) begin
      mant_q   <= mant_nx;
      exp_q    <= mant_zero ? '0 : exp_nx;
      shamt_q  <= shamt_nx;
      zero_q   <= mant_zero;
      denorm_q <= !mant_zero && !mant_nx[WIDTH-1];
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_mant   = mant_q;
  assign bus.out_exp    = exp_q;
  assign bus.out_shamt  = shamt_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_denorm = denorm_q;

endmodule

// File: tb/tb_norm_shift_seq.sv
// tb/tb_norm_shift_seq.sv - self-checking bench for norm_shift_seq
module tb_norm_shift_seq;

  localparam int WIDTH = 64;
  localparam int STEP  = 2;
  localparam int EXP_W = 11;

  typedef struct packed {
    logic [63:0] mant;
    logic [10:0] exp;
    logic [6:0]  shamt;
    logic        zero;
    logic        denorm;
    int          lat;
  } res_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  norm_shift_seq_if #(.WIDTH(WIDTH), .EXP_W(EXP_W)) bus ();

  norm_shift_seq #(.WIDTH(WIDTH), .STEP(STEP), .EXP_W(EXP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges from the accept edge to the first sample showing out_valid.
  function automatic int lat_for(input int s);
`ifdef NORM_SINGLE_CYCLE_EN
    return 1;
`else
    return (s + STEP - 1) / STEP + 1;
`endif
  endfunction

  // Reference: normalise in one go from the rules, then derive the latency.
  function automatic res_t model(input logic [63:0] m, input logic [10:0] e);
    res_t r;
    int   lzc;
    int   ei;
    int   s;
    r  = '0;
    ei = int'(e);
    if (m == 64'd0) begin
      r.zero = 1'b1;
      r.lat  = lat_for(0);
      return r;
    end
    lzc = 0;
    while (m[63 - lzc] == 1'b0) lzc++;
    if (ei == 0)          s = 0;
    else if (lzc < ei - 1) s = lzc;
    else                  s = ei - 1;
    r.mant   = m << s;
    r.exp    = 11'(ei - s);
    r.shamt  = 7'(s);
    r.denorm = !r.mant[63];
    r.lat    = lat_for(s);
    return r;
  endfunction

  function automatic res_t mk(input logic [63:0] m, input int e, input int sh,
                              input logic z, input logic d);
    res_t r;
    r.mant = m; r.exp = 11'(e); r.shamt = 7'(sh); r.zero = z; r.denorm = d;
    r.lat = lat_for(sh);
    return r;
  endfunction

  // Drives one operand, waits (bounded) for the result, optionally stalls hold cycles.
  task automatic do_op(input logic [63:0] m, input logic [10:0] e, input int hold,
                       output res_t r);
    int guard;
    int cnt;
    r = '0;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.in_valid  = 1'b1;
    bus.in_mant   = m;
    bus.in_exp    = e;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!bus.out_valid && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    r.mant   = bus.out_mant;
    r.exp    = bus.out_exp;
    r.shamt  = bus.out_shamt;
    r.zero   = bus.out_zero;
    r.denorm = bus.out_denorm;
    r.lat    = cnt;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b1;
    #12;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    total++;
    if ({bus.out_mant, bus.out_exp, bus.out_shamt, bus.out_zero, bus.out_denorm} !== '0) begin
      bad++;
      $display("FAIL reset_out: mant=%h exp=%0d shamt=%0d zero=%b denorm=%b want all 0",
               bus.out_mant, bus.out_exp, bus.out_shamt, bus.out_zero, bus.out_denorm);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    res_t obs;
    res_t want;
    logic [63:0] mv [5];
    int          ev [5];
    res_t        wv [5];
    mv[0] = 64'h8000_0000_0000_0001; ev[0] = 100; wv[0] = mk(64'h8000_0000_0000_0001, 100, 0, 0, 0);
    mv[1] = 64'h0F00_0000_0000_0000; ev[1] = 100; wv[1] = mk(64'hF000_0000_0000_0000, 96, 4, 0, 0);
    mv[2] = 64'h0000_0000_0000_0001; ev[2] = 5;   wv[2] = mk(64'h10, 1, 4, 0, 1);
    mv[3] = 64'h0;                   ev[3] = 7;   wv[3] = mk(64'h0, 0, 0, 1, 0);
    mv[4] = 64'h1;                   ev[4] = 0;   wv[4] = mk(64'h1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      want = wv[i];
      do_op(mv[i], 11'(ev[i]), 0, obs);
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL directed_%0d: got mant=%h exp=%0d sh=%0d z=%b d=%b lat=%0d want mant=%h exp=%0d sh=%0d z=%b d=%b lat=%0d",
                 i, obs.mant, obs.exp, obs.shamt, obs.zero, obs.denorm, obs.lat,
                 want.mant, want.exp, want.shamt, want.zero, want.denorm, want.lat);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t want;
    int   cnt;
    want = mk(64'hF000_0000_0000_0000, 96, 4, 0, 0);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_mant   = 64'h0F00_0000_0000_0000;
    bus.in_exp    = 11'd100;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!bus.out_valid && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    total++;
    if (cnt != want.lat) begin
      bad++;
      $display("FAIL bp_latency: got %0d want %0d", cnt, want.lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = (i == 2);
      bus.in_mant  = 64'h0000_0000_0000_00FF;
      bus.in_exp   = 11'd50;
      @(posedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_mant !== want.mant ||
          bus.out_exp !== want.exp || bus.out_shamt !== want.shamt) begin
        bad++;
        $display("FAIL bp_hold_%0d: valid=%b ready=%b mant=%h exp=%0d sh=%0d want 1 0 %h %0d %0d",
                 i, bus.out_valid, bus.in_ready, bus.out_mant, bus.out_exp, bus.out_shamt,
                 want.mant, want.exp, want.shamt);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_no_accept: valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_async_reset();
    res_t obs;
    res_t want;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_mant   = 64'h0F00_0000_0000_0000;
    bus.in_exp    = 11'd100;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_mant !== 64'd0) begin
      bad++;
      $display("FAIL async_rst: valid=%b ready=%b mant=%h want 0 1 0",
               bus.out_valid, bus.in_ready, bus.out_mant);
    end
    @(negedge clk);
    rst = 1'b0;
    want = mk(64'hF000_0000_0000_0000, 96, 4, 0, 0);
    do_op(64'h0F00_0000_0000_0000, 11'd100, 0, obs);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL async_after: got mant=%h exp=%0d sh=%0d lat=%0d want mant=%h exp=%0d sh=%0d lat=%0d",
               obs.mant, obs.exp, obs.shamt, obs.lat, want.mant, want.exp, want.shamt, want.lat);
    end
  endtask

  task automatic test_random();
    res_t        obs;
    res_t        want;
    logic [63:0] m;
    logic [10:0] e;
    for (int i = 0; i < 150; i++) begin
      m = {$urandom, $urandom};
      m = m >> $urandom_range(0, 64);
      case ($urandom_range(0, 2))
        0:       e = 11'($urandom_range(0, 8));
        1:       e = 11'($urandom_range(0, 70));
        default: e = 11'($urandom_range(0, 2047));
      endcase
      want = model(m, e);
      do_op(m, e, $urandom_range(0, 3), obs);
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL random_%0d in=%h/%0d: got mant=%h exp=%0d sh=%0d z=%b d=%b lat=%0d want mant=%h exp=%0d sh=%0d z=%b d=%b lat=%0d",
                 i, m, e, obs.mant, obs.exp, obs.shamt, obs.zero, obs.denorm, obs.lat,
                 want.mant, want.exp, want.shamt, want.zero, want.denorm, want.lat);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
